mem_port_arbiter: RTL

Sequencing arbiter that shares a single `ram` instance between the fetch requester (80-bit instruction reads) and the memory-access requester (64-bit data reads and writes). It replaces the split iram/dram arrangement. It serialises requests through a fixed-latency issue/wait/respond state machine, drives the RAM enables, address and write data, and returns captured RAM outputs with a one-cycle acknowledge. Data requests have priority. A starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one RAM between the instruction-fetch port and the data port.
// Requests are serialised through IDLE -> ISSUE -> WAIT(LAT) -> DONE; data wins unless fetch is starving.
module mem_port_arbiter #(
  parameter int LAT          = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_ack_o,
  output logic [79:0] if_instr_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [63:0] d_rdata_o,
  output logic        d_err_o,
  output logic        ram_read_en_o,
  output logic        ram_write_en_o,
  output logic        ram_read_instruction_en_o,
  output logic [63:0] ram_addr_o,
  output logic [63:0] ram_write_data_o,
  input  logic [63:0] ram_read_data_i,
  input  logic [79:0] ram_read_instruction_i,
  input  logic        ram_dmem_error_i,
  output logic        busy_o,
  output logic        owner_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [2:0] WAIT_LOAD  = 3'(LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  wait_q, wait_d;
  logic        capture_s;
  logic        active_s;

  logic        if_ack_q, if_ack_d;
  logic [79:0] if_instr_q, if_instr_d;
  logic        if_err_q, if_err_d;
  logic        d_ack_q, d_ack_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        ins_en_q, ins_en_d;
  logic [63:0] ram_addr_q, ram_addr_d;
  logic [63:0] ram_wdata_q, ram_wdata_d;
  logic        busy_q, busy_d;

  // Next-state, arbitration and registered-output next values.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    capture_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req_i || if_req_i) begin
          state_d = ISSUE;
          if (d_req_i && !(if_req_i && (starve_q == STARVE_MAX))) begin
            owner_d = 1'b1;
            we_d    = d_we_i;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
            if (if_req_i) begin
              starve_d = (starve_q == 4'hF) ? starve_q : (starve_q + 4'd1);
            end else begin
              starve_d = 4'd0;
            end
          end else begin
            owner_d  = 1'b0;
            we_d     = 1'b0;
            addr_d   = if_addr_i;
            wdata_d  = 64'd0;
            starve_d = 4'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = WAIT_LOAD;
      end
      WAIT: begin
        if (wait_q == 3'd0) begin
          capture_s = 1'b1;
          state_d   = DONE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    active_s    = (state_d == ISSUE) || (state_d == WAIT);
    ins_en_d    = active_s && !owner_d;
    rd_en_d     = active_s && owner_d && !we_d;
    wr_en_d     = (state_d == ISSUE) && owner_d && we_d;
    ram_addr_d  = active_s ? addr_d : 64'd0;
    ram_wdata_d = (active_s && owner_d && we_d) ? wdata_d : 64'd0;
    if_ack_d    = (state_d == DONE) && !owner_d;
    d_ack_d     = (state_d == DONE) && owner_d;
    busy_d      = (state_d != IDLE);

    if_instr_d = if_instr_q;
    if_err_d   = if_err_q;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
    // Response registers only change when their own port's transaction completes.
    if (capture_s && !owner_q) begin
      if_instr_d = ram_read_instruction_i;
      if_err_d   = ram_dmem_error_i;
    end else if (capture_s && owner_q) begin
      d_rdata_d = we_q ? 64'd0 : ram_read_data_i;
      d_err_d   = ram_dmem_error_i;
    end else begin
      if_instr_d = if_instr_q;
    end
  end

  // State, latched request and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      wait_q      <= 3'd0;
      if_ack_q    <= 1'b0;
      if_instr_q  <= 80'd0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= 64'd0;
      d_err_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      ins_en_q    <= 1'b0;
      ram_addr_q  <= 64'd0;
      ram_wdata_q <= 64'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      if_ack_q    <= if_ack_d;
      if_instr_q  <= if_instr_d;
      if_err_q    <= if_err_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      ins_en_q    <= ins_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack_o                  = if_ack_q;
  assign if_instr_o                = if_instr_q;
  assign if_err_o                  = if_err_q;
  assign d_ack_o                   = d_ack_q;
  assign d_rdata_o                 = d_rdata_q;
  assign d_err_o                   = d_err_q;
  assign ram_read_en_o             = rd_en_q;
  assign ram_write_en_o            = wr_en_q;
  assign ram_read_instruction_en_o = ins_en_q;
  assign ram_addr_o                = ram_addr_q;
  assign ram_write_data_o          = ram_wdata_q;
  assign busy_o                    = busy_q;
  assign owner_o                   = owner_q;

endmodule
